// File: rtl/icache_prefetch_engine.sv
// rtl/icache_prefetch_engine.sv - next-line instruction prefetcher with tag-matched request table
// Keeps a base line and a run-ahead count. Cancelled requests stay allocated as stale until their tag returns.
module icache_prefetch_engine #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int DIST   = 8,
  parameter int IDX_W  = 5,
  parameter int TAG_W  = 8,
  parameter int MTAG_W = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       pf_enable,
  input  logic [$clog2(DIST+1)-1:0]  cfg_distance,
  input  logic                       fetch_valid,
  input  logic [XLEN-1:0]            fetch_addr,
  input  logic [1:0]                 fetch_advance,
  input  logic                       redirect,
  input  logic                       give_way,
  input  logic                       lookup_valid,
  output logic                       already_fetched,
  input  logic [MTAG_W-1:0]          mem_response,
  input  logic [MTAG_W-1:0]          mem_tag,
  output logic [1:0]                 pf_command,
  output logic [XLEN-1:0]            pf_addr,
  output logic                       pf_wr_enable,
  output logic [IDX_W-1:0]           pf_wr_index,
  output logic [TAG_W-1:0]           pf_wr_tag,
  output logic [$clog2(DEPTH+1)-1:0] pf_outstanding
);

  localparam int LINE_W = XLEN - 3;
  localparam int CMP_W  = IDX_W + TAG_W;
  localparam int DW     = $clog2(DIST + 1);
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int SW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_LOAD = 2'b01;

  logic [1:0]        state;
  logic [LINE_W-1:0] base_line;
  logic [DW-1:0]     ahead;
  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_stale;
  logic [MTAG_W-1:0] ent_mtag [DEPTH];
  logic [CMP_W-1:0]  ent_line [DEPTH];

  logic [DW-1:0]     dist_eff;
  logic [1:0]        adv;
  logic [LINE_W-1:0] fetch_line;
  logic [LINE_W-1:0] req_line;
  logic              has_free;
  logic              hit;
  logic              issue;
  logic              accept;
  logic              hold_next;
  logic              live_match;
  logic [SW-1:0]     free_idx;
  logic [SW-1:0]     hit_idx;
  logic [DEPTH-1:0]  valid_next;
  logic [CW-1:0]     cnt_now;
  logic [CW-1:0]     cnt_next;
  logic [DW:0]       ahead_up;
  logic [DW:0]       ahead_dn;
  logic [DW-1:0]     ahead_adv;
  logic              unused_addr_bits;

  assign dist_eff         = (cfg_distance > DW'(DIST)) ? DW'(DIST) : cfg_distance;
  assign adv              = (fetch_advance == 2'd3) ? 2'd2 : fetch_advance;
  assign fetch_line       = fetch_addr[XLEN-1:3];
  assign req_line         = base_line + LINE_W'(ahead);
  assign unused_addr_bits = ^fetch_addr[2:0];

  // Downward scan so the lowest matching index wins for both searches.
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    hit      = 1'b0;
    hit_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        has_free = 1'b1;
        free_idx = SW'(i);
      end
      if (ent_valid[i] && (mem_tag != '0) && (ent_mtag[i] == mem_tag)) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  assign issue  = (state == S_STREAM) && pf_enable && !redirect && !give_way && has_free;
  assign accept = issue && (mem_response != '0);

  assign pf_command   = issue ? BUS_LOAD : BUS_NONE;
  assign pf_addr      = {req_line, 3'b000};
  assign pf_wr_enable = hit && !ent_stale[hit_idx];
  assign pf_wr_index  = hit ? ent_line[hit_idx][IDX_W-1:0] : '0;
  assign pf_wr_tag    = hit ? ent_line[hit_idx][CMP_W-1:IDX_W] : '0;

  always_comb begin
    live_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && !ent_stale[i] && (ent_line[i] == fetch_line[CMP_W-1:0]))
        live_match = 1'b1;
    end
  end

  assign already_fetched = lookup_valid && live_match;

  always_comb begin
    valid_next = ent_valid;
    if (hit)
      valid_next[hit_idx] = 1'b0;
    if (accept)
      valid_next[free_idx] = 1'b1;
    cnt_now  = '0;
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_now  = cnt_now + CW'(ent_valid[i]);
      cnt_next = cnt_next + CW'(valid_next[i]);
    end
  end

  assign pf_outstanding = cnt_now;

  // Run-ahead after this cycle's consumption and accept, floored at 0 and capped at DIST.
  always_comb begin
    ahead_up  = {1'b0, ahead} + {{DW{1'b0}}, accept};
    ahead_dn  = '0;
    ahead_adv = '0;
    if (ahead_up > (DW+1)'(adv)) begin
      ahead_dn  = ahead_up - (DW+1)'(adv);
      ahead_adv = (ahead_dn > (DW+1)'(DIST)) ? DW'(DIST) : ahead_dn[DW-1:0];
    end
  end

  assign hold_next = (ahead_adv >= dist_eff) || (cnt_next == CW'(DEPTH));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      base_line <= '0;
      ahead     <= '0;
      ent_valid <= '0;
      ent_stale <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_mtag[i] <= '0;
        ent_line[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (redirect && ent_valid[i])
          ent_stale[i] <= 1'b1;
        if (hit && (hit_idx == SW'(i)))
          ent_valid[i] <= 1'b0;
        if (accept && (free_idx == SW'(i))) begin
          ent_valid[i] <= 1'b1;
          ent_stale[i] <= 1'b0;
          ent_mtag[i]  <= mem_response;
          ent_line[i]  <= req_line[CMP_W-1:0];
        end
      end

      if (redirect) begin
        if (fetch_valid) begin
          state     <= S_STREAM;
          base_line <= fetch_line;
          ahead     <= '0;
        end else begin
          state <= S_IDLE;
        end
      end else if (state == S_IDLE) begin
        if (fetch_valid) begin
          state     <= S_STREAM;
          base_line <= fetch_line;
          ahead     <= '0;
        end
      end else begin
        base_line <= base_line + LINE_W'(adv);
        ahead     <= ahead_adv;
        state     <= hold_next ? S_HOLD : S_STREAM;
      end
    end
  end

endmodule

// File: tb/tb_icache_prefetch_engine.sv
// tb/tb_icache_prefetch_engine.sv - bench for icache_prefetch_engine (DEPTH 4 and DEPTH 2 instances)
module tb_icache_prefetch_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        pf_enable;
  logic [3:0]  cfg_distance;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic [1:0]  fetch_advance;
  logic        redirect;
  logic        give_way;
  logic        lookup_valid;
  logic [3:0]  mem_response;
  logic [3:0]  mem_tag;

  logic        af_a, wre_a, af_b, wre_b;
  logic [1:0]  cmd_a, cmd_b;
  logic [31:0] addr_a, addr_b;
  logic [4:0]  wri_a, wri_b;
  logic [7:0]  wrt_a, wrt_b;
  logic [2:0]  out_a;
  logic [1:0]  out_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  icache_prefetch_engine #(.DEPTH(4)) dut_a (
    .clock(clock), .reset(reset), .pf_enable(pf_enable), .cfg_distance(cfg_distance),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_advance(fetch_advance),
    .redirect(redirect), .give_way(give_way), .lookup_valid(lookup_valid),
    .already_fetched(af_a), .mem_response(mem_response), .mem_tag(mem_tag),
    .pf_command(cmd_a), .pf_addr(addr_a), .pf_wr_enable(wre_a), .pf_wr_index(wri_a),
    .pf_wr_tag(wrt_a), .pf_outstanding(out_a));

  icache_prefetch_engine #(.DEPTH(2)) dut_b (
    .clock(clock), .reset(reset), .pf_enable(pf_enable), .cfg_distance(cfg_distance),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_advance(fetch_advance),
    .redirect(redirect), .give_way(give_way), .lookup_valid(lookup_valid),
    .already_fetched(af_b), .mem_response(mem_response), .mem_tag(mem_tag),
    .pf_command(cmd_b), .pf_addr(addr_b), .pf_wr_enable(wre_b), .pf_wr_index(wri_b),
    .pf_wr_tag(wrt_b), .pf_outstanding(out_b));

  // Model: outstanding requests as a list; mode 0 = no base, 1 = issuing, 2 = holding.
  typedef struct {
    int          inst;
    logic [3:0]  mtag;
    logic [28:0] line;
    bit          stale;
  } ent_t;

  ent_t        ents[$];
  logic [28:0] m_base [2];
  int          m_ahead [2];
  int          m_mode [2];

  function automatic int depth_of(int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic int m_dist();
    return (cfg_distance > 4'd8) ? 8 : int'(cfg_distance);
  endfunction

  function automatic int m_cnt(int k);
    int n = 0;
    foreach (ents[i]) if (ents[i].inst == k) n++;
    return n;
  endfunction

  function automatic int m_find(int k);
    if (mem_tag == 4'd0) return -1;
    foreach (ents[i]) if (ents[i].inst == k && ents[i].mtag == mem_tag) return i;
    return -1;
  endfunction

  function automatic bit m_issue(int k);
    return (m_mode[k] == 1) && pf_enable && !redirect && !give_way && (m_cnt(k) < depth_of(k));
  endfunction

  task automatic model_reset();
    ents.delete();
    for (int k = 0; k < 2; k++) begin
      m_base[k] = '0; m_ahead[k] = 0; m_mode[k] = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cyc=%0d %s actual=%h expected=%h", cyc, nm, act, exp);
    end
  endtask

  task automatic compare(input int k, input logic [1:0] cmd, input logic [31:0] addr,
                         input logic wre, input logic [4:0] wri, input logic [7:0] wrt,
                         input logic af, input int outst);
    string       p = (k == 0) ? "a_" : "b_";
    bit          iss = m_issue(k);
    int          mi = m_find(k);
    bit          ewre;
    bit          eaf = 0;
    logic [28:0] rl = m_base[k] + 29'(m_ahead[k]);
    chk({p, "cmd"}, 32'(cmd), iss ? 32'd1 : 32'd0);
    if (iss) chk({p, "addr"}, addr, {rl, 3'b000});
    ewre = (mi >= 0) && !ents[mi].stale;
    chk({p, "wr_enable"}, 32'(wre), 32'(ewre));
    if (ewre) begin
      chk({p, "wr_index"}, 32'(wri), 32'(ents[mi].line[4:0]));
      chk({p, "wr_tag"}, 32'(wrt), 32'(ents[mi].line[12:5]));
    end
    if (lookup_valid)
      foreach (ents[i])
        if (ents[i].inst == k && !ents[i].stale && ents[i].line[12:0] == fetch_addr[15:3]) eaf = 1;
    chk({p, "already_fetched"}, 32'(af), 32'(eaf));
    chk({p, "outstanding"}, 32'(outst), 32'(m_cnt(k)));
  endtask

  task automatic m_step(input int k);
    bit          acc = m_issue(k) && (mem_response != 4'd0);
    int          mi = m_find(k);
    int          adv = (fetch_advance == 2'd3) ? 2 : int'(fetch_advance);
    int          a;
    logic [28:0] rl = m_base[k] + 29'(m_ahead[k]);
    ent_t        e;
    if (mi >= 0) ents.delete(mi);
    if (redirect)
      foreach (ents[i])
        if (ents[i].inst == k) begin
          e = ents[i]; e.stale = 1; ents[i] = e;
        end
    if (acc) begin
      e.inst = k; e.mtag = mem_response; e.line = rl; e.stale = 0;
      ents.push_back(e);
    end
    if (redirect || m_mode[k] == 0) begin
      if (fetch_valid) begin
        m_base[k] = fetch_addr[31:3]; m_ahead[k] = 0; m_mode[k] = 1;
      end else if (redirect) begin
        m_mode[k] = 0;
      end
    end else begin
      m_base[k] = m_base[k] + 29'(adv);
      a = m_ahead[k] - adv + int'(acc);
      if (a < 0) a = 0;
      if (a > 8) a = 8;
      m_ahead[k] = a;
      m_mode[k] = (a >= m_dist() || m_cnt(k) >= depth_of(k)) ? 2 : 1;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    compare(0, cmd_a, addr_a, wre_a, wri_a, wrt_a, af_a, int'(out_a));
    compare(1, cmd_b, addr_b, wre_b, wri_b, wrt_b, af_b, int'(out_b));
    @(posedge clock);
    if (!reset) model_reset();
    else begin
      m_step(0);
      m_step(1);
    end
    #1;
    cyc++;
  endtask

  task automatic clr();
    fetch_valid = 0; fetch_advance = 0; redirect = 0; give_way = 0;
    lookup_valid = 0; mem_response = 0; mem_tag = 0;
  endtask

  initial begin
    model_reset();
    reset = 0; pf_enable = 1; cfg_distance = 4; fetch_addr = 0;
    clr();
    tick(); tick();
    lookup_valid = 1;
    #1;
    chk("lit_rst_cmd", 32'(cmd_a), 32'd0);
    chk("lit_rst_addr", addr_a, 32'd0);
    chk("lit_rst_wre", 32'(wre_a), 32'd0);
    chk("lit_rst_wri", 32'(wri_a), 32'd0);
    chk("lit_rst_wrt", 32'(wrt_a), 32'd0);
    chk("lit_rst_af", 32'(af_a), 32'd0);
    chk("lit_rst_out", 32'(out_a), 32'd0);
    tick();
    reset = 1;

    // Stream from 0x100 at distance 4
    clr(); fetch_valid = 1; fetch_addr = 32'h100; tick();
    for (int i = 1; i <= 4; i++) begin
      clr(); mem_response = 4'(i);
      if (i == 3) begin fetch_addr = 32'h108; lookup_valid = 1; end
      #1;
      chk("lit_stream_cmd", 32'(cmd_a), 32'd1);
      chk("lit_stream_addr", addr_a, 32'h100 + 32'(8 * (i - 1)));
      if (i == 3) chk("lit_af_live", 32'(af_a), 32'd1);
      tick();
    end
    clr(); #1;
    chk("lit_hold_cmd", 32'(cmd_a), 32'd0);
    chk("lit_full_a", 32'(out_a), 32'd4);
    chk("lit_full_b", 32'(out_b), 32'd2);
    tick();

    // Completion of line 0x21, then advance
    clr(); mem_tag = 2; #1;
    chk("lit_install_en", 32'(wre_a), 32'd1);
    chk("lit_install_idx", 32'(wri_a), 32'h01);
    chk("lit_install_tag", 32'(wrt_a), 32'h01);
    tick();
    clr(); fetch_advance = 1; tick();
    clr(); mem_response = 5; #1;
    chk("lit_next_cmd", 32'(cmd_a), 32'd1);
    chk("lit_next_addr", addr_a, 32'h120);
    tick();

    // Give-way and rejects
    clr(); mem_tag = 1; tick();
    for (int i = 0; i < 3; i++) begin
      clr(); give_way = 1; if (i == 0) fetch_advance = 2;
      #1;
      chk("lit_giveway_a", 32'(cmd_a), 32'd0);
      chk("lit_giveway_b", 32'(cmd_b), 32'd0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      clr(); #1;
      chk("lit_reject_cmd", 32'(cmd_a), 32'd1);
      chk("lit_reject_addr", addr_a, 32'h128);
      if (i == 1) chk("lit_reject_noalloc", 32'(out_a), 32'd3);
      tick();
    end
    clr(); mem_response = 6; tick();

    // Redirect to 0x400 with requests in flight
    clr(); redirect = 1; fetch_valid = 1; fetch_addr = 32'h400; mem_response = 7; #1;
    chk("lit_redir_cmd", 32'(cmd_a), 32'd0);
    tick();
    clr(); mem_tag = 3; #1;
    chk("lit_stale_wre", 32'(wre_a), 32'd0);
    tick();
    clr(); mem_tag = 4; mem_response = 8; #1;
    chk("lit_rebase_addr", addr_a, 32'h400);
    chk("lit_rebase_cmd", 32'(cmd_a), 32'd1);
    chk("lit_stale_wre2", 32'(wre_a), 32'd0);
    tick();
    clr(); mem_response = 9; lookup_valid = 1; fetch_addr = 32'h120; #1;
    chk("lit_rebase_addr2", addr_a, 32'h408);
    chk("lit_af_stale", 32'(af_a), 32'd0);
    tick();
    clr(); mem_tag = 5; lookup_valid = 1; fetch_addr = 32'h400; #1;
    chk("lit_af_new", 32'(af_a), 32'd1);
    tick();
    clr(); mem_tag = 6; tick();
    clr(); mem_tag = 8; #1;
    chk("lit_install2_en", 32'(wre_a), 32'd1);
    chk("lit_install2_idx", 32'(wri_a), 32'h00);
    chk("lit_install2_tag", 32'(wrt_a), 32'h04);
    tick();
    clr(); mem_tag = 9; mem_response = 10; tick();

    // Disabled, then redirect without a target
    clr(); pf_enable = 0; mem_response = 11; #1;
    chk("lit_disabled_cmd", 32'(cmd_a), 32'd0);
    tick();
    pf_enable = 1;
    clr(); redirect = 1; tick();
    clr(); mem_response = 12; #1;
    chk("lit_idle_cmd", 32'(cmd_a), 32'd0);
    tick();

    // Asynchronous reset with an entry outstanding
    clr(); reset = 0; #1;
    chk("lit_async_out_a", 32'(out_a), 32'd0);
    model_reset();
    tick(); tick();
    reset = 1;

    // Clamped distance and line wrap; stale response from before reset
    cfg_distance = 15;
    clr(); fetch_valid = 1; fetch_addr = 32'hFFFF_FFF8; mem_tag = 10; #1;
    chk("lit_post_reset_wre", 32'(wre_a), 32'd0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      clr(); mem_response = 4'(i); mem_tag = 4'(i - 1); #1;
      if (i == 1) chk("lit_wrap_first", addr_b, 32'hFFFF_FFF8);
      if (i == 2) begin
        chk("lit_wrap_zero", addr_b, 32'h0);
        chk("lit_wrap_cmd", 32'(cmd_b), 32'd1);
      end
      if (i == 9) begin
        chk("lit_clamp_hold", 32'(cmd_b), 32'd0);
        chk("lit_clamp_out", 32'(out_b), 32'd1);
      end
      tick();
    end
    clr(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
